digit_scan_ctrl: RTL

//  Scan scheduler for the 8-digit multiplexed 7-segment display. Generates the per-digit dwell tick,

---
 rtl/digit_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 8-digit 7-segment scan scheduler with an anti-ghost blanking gap and frame-boundary config apply.
// Outputs registered (one cycle after the deciding state); no backpressure. Define SCAN_LZB_EN for leading-zero blanking.
module digit_scan_ctrl #(
    parameter logic [16:0] DIV_MAX   = 17'd99_999,
    parameter logic [7:0]  BLANK_CYC = 8'd16
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        run,
    input  logic        cfg_we,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  dig_mask,
    output logic [7:0]  sel,
    output logic [7:0]  seg,
    output logic [2:0]  st,
    output logic        frame_done,
    output logic        cfg_pend
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t      state_q, state_nxt;
    logic [16:0] div_q, div_nxt;
    logic [7:0]  bcnt_q, bcnt_nxt;
    logic [2:0]  st_nxt, scan_nxt;
    logic [31:0] act_data, act_data_nxt, pend_data, pend_data_nxt;
    logic [7:0]  act_dp, act_dp_nxt, pend_dp, pend_dp_nxt;
    logic [7:0]  act_mask, act_mask_nxt, pend_mask, pend_mask_nxt;
    logic        cfg_pend_nxt, boundary;
    logic [7:0]  sel_nxt, seg_nxt;
    logic [3:0]  nib;
    logic [6:0]  glyph;
`ifdef SCAN_LZB_EN
    logic        lz;
`endif

    function automatic logic [2:0] lowest_en(input logic [7:0] m);
        lowest_en = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest_en = 3'(i);
    endfunction

    // Offset 8 folds back onto cur itself, so a single enabled digit wraps to itself.
    function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] cur);
        next_en = cur;
        for (int k = 8; k >= 1; k--)
            if (m[cur + 3'(k)]) next_en = cur + 3'(k);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_nxt     = state_q;
        div_nxt       = div_q;
        bcnt_nxt      = bcnt_q;
        st_nxt        = st;
        scan_nxt      = st;
        act_data_nxt  = act_data;
        act_dp_nxt    = act_dp;
        act_mask_nxt  = act_mask;
        pend_data_nxt = pend_data;
        pend_dp_nxt   = pend_dp;
        pend_mask_nxt = pend_mask;
        cfg_pend_nxt  = cfg_pend;
        boundary      = 1'b0;

        if (cfg_we) begin
            if (state_q == IDLE) begin
                act_data_nxt = data;
                act_dp_nxt   = dp;
                act_mask_nxt = dig_mask;
            end else begin
                pend_data_nxt = data;
                pend_dp_nxt   = dp;
                pend_mask_nxt = dig_mask;
                cfg_pend_nxt  = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (run && act_mask != 8'd0) begin
                    state_nxt = SHOW;
                    st_nxt    = lowest_en(act_mask);
                    div_nxt   = '0;
                end
            end
            SHOW: begin
                if (!run || act_mask == 8'd0) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else if (div_q == DIV_MAX) begin
                    div_nxt   = '0;
                    bcnt_nxt  = '0;
                    state_nxt = BLANK;
                end else begin
                    div_nxt = div_q + 17'd1;
                end
            end
            BLANK: begin
                if (!run || act_mask == 8'd0) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else if (bcnt_q == BLANK_CYC - 8'd1) begin
                    scan_nxt = next_en(act_mask, st);
                    if (scan_nxt <= st) begin
                        // Frame boundary: the only point where a pending config may take effect.
                        boundary = 1'b1;
                        if (cfg_pend) begin
                            act_data_nxt = pend_data;
                            act_dp_nxt   = pend_dp;
                            act_mask_nxt = pend_mask;
                            scan_nxt     = lowest_en(pend_mask);
                            if (!cfg_we) cfg_pend_nxt = 1'b0;
                        end
                    end
                    if (act_mask_nxt == 8'd0) begin
                        state_nxt = IDLE;
                        div_nxt   = '0;
                    end else begin
                        state_nxt = SHOW;
                        st_nxt    = scan_nxt;
                    end
                end else begin
                    bcnt_nxt = bcnt_q + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nib   = act_data_nxt[{st_nxt, 2'b00} +: 4];
        glyph = seg7(nib);
`ifdef SCAN_LZB_EN
        lz = (st_nxt != 3'd0);
        for (int j = 0; j < 8; j++)
            if (3'(j) >= st_nxt && act_mask_nxt[j] && act_data_nxt[4*j +: 4] != 4'd0) lz = 1'b0;
        if (lz) glyph = 7'h7F;
`endif
        sel_nxt = 8'hFF;
        seg_nxt = 8'hFF;
        if (state_nxt == SHOW) begin
            sel_nxt = ~(8'd1 << st_nxt);
            seg_nxt = {~act_dp_nxt[st_nxt], glyph};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bcnt_q     <= '0;
            st         <= '0;
            sel        <= 8'hFF;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
            cfg_pend   <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_mask   <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_mask  <= '0;
        end else begin
            state_q    <= state_nxt;
            div_q      <= div_nxt;
            bcnt_q     <= bcnt_nxt;
            st         <= st_nxt;
            sel        <= sel_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
            cfg_pend   <= cfg_pend_nxt;
            act_data   <= act_data_nxt;
            act_dp     <= act_dp_nxt;
            act_mask   <= act_mask_nxt;
            pend_data  <= pend_data_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_mask  <= pend_mask_nxt;
        end
    end

endmodule
